// File: rtl/rice_core_pkg.sv
// rice_core_pkg: shared CSR operation encoding and CSR address layout constants.
package rice_core_pkg;

   localparam int CSR_ADDRESS_WIDTH = 12;
   localparam int CSR_PRIV_LSB      = 8;

   typedef enum logic [1:0] {
      CSR_OP_RW = 2'd0,
      CSR_OP_RS = 2'd1,
      CSR_OP_RC = 2'd2
   } rice_core_csr_op;

endpackage

// File: rtl/rice_bus_if.sv
// rice_bus_if: valid/ready request channel plus valid/ready response channel.
interface rice_bus_if #(
   parameter int ADDRESS_WIDTH = 12,
   parameter int DATA_WIDTH    = 32
);

   logic                     request_valid;
   logic                     request_ready;
   logic                     write;
   logic [ADDRESS_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0]    write_data;
   logic                     response_valid;
   logic                     response_ready;
   logic [DATA_WIDTH-1:0]    read_data;
   logic                     error;

   modport master (
      output request_valid, write, address, write_data, response_ready,
      input  request_ready, response_valid, read_data, error
   );

   modport slave (
      input  request_valid, write, address, write_data, response_ready,
      output request_ready, response_valid, read_data, error
   );

endinterface

// File: rtl/rice_core_csr_access_ctrl.sv
// rice_core_csr_access_ctrl: runs one Zicsr instruction as a checked read-modify-write
// on the core CSR bus and returns the old CSR value with an error flag.
module rice_core_csr_access_ctrl
   import rice_core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [1:0]                   i_privilege_level,
   input  logic                         i_valid,
   input  logic [1:0]                   i_op,
   input  logic [CSR_ADDRESS_WIDTH-1:0] i_address,
   input  logic [XLEN-1:0]              i_wdata,
   input  logic                         i_read_skip,
   input  logic                         i_write_skip,
   input  logic                         i_flush,
   output logic                         o_busy,
   output logic                         o_done,
   output logic [XLEN-1:0]              o_rdata,
   output logic                         o_error,
   rice_bus_if.master                   csr_if
);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_RSP,
      WR_REQ,
      WR_RSP,
      DONE
   } state_e;

   state_e                         state_q, state_d;
   logic [1:0]                     op_q, op_d;
   logic [CSR_ADDRESS_WIDTH-1:0]   address_q, address_d;
   logic [XLEN-1:0]                wdata_q, wdata_d;
   logic                           read_skip_q, read_skip_d;
   logic                           write_skip_q, write_skip_d;
   logic [XLEN-1:0]                old_q, old_d;
   logic                           error_q, error_d;
   logic                           flush_q, flush_d;
   logic                           flush_any;
   logic                           illegal;

   function automatic logic is_illegal(
      input logic [1:0]                   op,
      input logic [CSR_ADDRESS_WIDTH-1:0] address,
      input logic [1:0]                   privilege,
      input logic                         write_skip
   );
      return (address[CSR_PRIV_LSB+1:CSR_PRIV_LSB] > privilege)
          || (op == 2'd3)
          || (address[CSR_ADDRESS_WIDTH-1:CSR_ADDRESS_WIDTH-2] == 2'b11 && !write_skip);
   endfunction

   function automatic logic [XLEN-1:0] write_value(
      input logic [1:0]      op,
      input logic [XLEN-1:0] old,
      input logic [XLEN-1:0] src
   );
      return (op == CSR_OP_RS) ? (old | src) : (op == CSR_OP_RC) ? (old & ~src) : src;
   endfunction

   assign illegal   = is_illegal(i_op, i_address, i_privilege_level, i_write_skip);
   // A flush seen mid-transaction is remembered until the bus handshake drains.
   assign flush_any = i_flush || flush_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         op_q         <= '0;
         address_q    <= '0;
         wdata_q      <= '0;
         read_skip_q  <= 1'b0;
         write_skip_q <= 1'b0;
         old_q        <= '0;
         error_q      <= 1'b0;
         flush_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         address_q    <= address_d;
         wdata_q      <= wdata_d;
         read_skip_q  <= read_skip_d;
         write_skip_q <= write_skip_d;
         old_q        <= old_d;
         error_q      <= error_d;
         flush_q      <= flush_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      address_d    = address_q;
      wdata_d      = wdata_q;
      read_skip_d  = read_skip_q;
      write_skip_d = write_skip_q;
      old_d        = old_q;
      error_d      = error_q;
      flush_d      = (state_q != IDLE) && (state_q != DONE) && flush_any;
      unique case (state_q)
         IDLE: begin
            if (i_valid && !i_flush) begin
               op_d         = i_op;
               address_d    = i_address;
               wdata_d      = i_wdata;
               read_skip_d  = i_read_skip;
               write_skip_d = i_write_skip;
               old_d        = '0;
               error_d      = illegal;
               state_d      = illegal ? DONE
                            : (i_read_skip && i_op == CSR_OP_RW) ? WR_REQ : RD_REQ;
            end
         end
         RD_REQ: begin
            if (csr_if.request_ready) state_d = RD_RSP;
         end
         RD_RSP: begin
            if (csr_if.response_valid) begin
               old_d   = csr_if.read_data;
               error_d = csr_if.error;
               state_d = flush_any ? IDLE
                       : (csr_if.error || write_skip_q) ? DONE : WR_REQ;
            end
         end
         WR_REQ: begin
            if (csr_if.request_ready) state_d = WR_RSP;
            else if (flush_any) state_d = IDLE;
         end
         WR_RSP: begin
            if (csr_if.response_valid) begin
               error_d = csr_if.error;
               state_d = flush_any ? IDLE : DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_busy                = state_q != IDLE;
      o_done                = (state_q == DONE) && !i_flush;
      o_rdata               = old_q;
      o_error               = error_q;
      csr_if.request_valid  = (state_q == RD_REQ) || (state_q == WR_REQ);
      csr_if.write          = state_q == WR_REQ;
      csr_if.address        = address_q;
      csr_if.write_data     = write_value(op_q, old_q, wdata_q);
      csr_if.response_ready = (state_q == RD_RSP) || (state_q == WR_RSP);
   end

endmodule
